// File: rtl/c5_div_seq.sv
// Iterative radix-2 restoring divider for DIV/DIVU: quotient (LO) and remainder (HI).
// Signed operands are folded to magnitudes in PREP and the signs are re-applied in FIX.
module c5_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             I_clk,
  input  logic             I_reset,
  input  logic             I_start,
  input  logic             I_signed,
  input  logic [WIDTH-1:0] I_a,
  input  logic [WIDTH-1:0] I_b,
  output logic             O_busy,
  output logic             O_done,
  output logic [WIDTH-1:0] O_quotient,
  output logic [WIDTH-1:0] O_remainder
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;     // original dividend, kept for the divide-by-zero remainder
  logic [WIDTH-1:0] b_q, b_d;     // raw divisor, then its magnitude after PREP
  logic [WIDTH-1:0] quo_q, quo_d; // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_out_q, q_out_d, r_out_q, r_out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgn_q, sgn_d, neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic             div0_q, div0_d, done_q, done_d;
  logic [WIDTH:0]   shifted, diff;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    div0_d  = div0_q;
    done_d  = 1'b0;
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, b_q};
    case (state_q)
      IDLE: begin
        if (I_start) begin
          a_d     = I_a;
          b_d     = I_b;
          sgn_d   = I_signed;
          state_d = PREP;
        end
      end
      PREP: begin
        neg_a_d = sgn_q & a_q[WIDTH-1];
        neg_b_d = sgn_q & b_q[WIDTH-1];
        quo_d   = neg_a_d ? (~a_q + 1'b1) : a_q;
        b_d     = neg_b_d ? (~b_q + 1'b1) : b_q;
        div0_d  = (b_q == '0);
        rem_d   = '0;
        cnt_d   = CNT_INIT;
        state_d = ITER;
      end
      ITER: begin
        // A set top bit in shifted already exceeds any divisor, so the subtract
        // always succeeds then and the dropped bit never matters.
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        if (div0_q) begin
          q_out_d = '1;
          r_out_d = a_q;
        end else begin
          q_out_d = (neg_a_q ^ neg_b_q) ? (~quo_q + 1'b1) : quo_q;
          r_out_d = neg_a_q ? (~rem_q + 1'b1) : rem_q;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      q_out_q <= '0;
      r_out_q <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      div0_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      div0_q  <= div0_d;
      done_q  <= done_d;
    end
  end

  assign O_busy      = (state_q != IDLE);
  assign O_done      = done_q;
  assign O_quotient  = q_out_q;
  assign O_remainder = r_out_q;

endmodule

// File: tb/tb_c5_div_seq.sv
// Randomized + directed bench for c5_div_seq against a plain-arithmetic division model.
module tb_c5_div_seq;
  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         I_reset, I_start, I_signed;
  logic [W-1:0] I_a, I_b;
  logic         O_busy, O_done;
  logic [W-1:0] O_quotient, O_remainder;
  int           total = 0;
  int           bad = 0;

  c5_div_seq #(.WIDTH(W)) dut (
    .I_clk(clk), .I_reset(I_reset), .I_start(I_start), .I_signed(I_signed),
    .I_a(I_a), .I_b(I_b), .O_busy(O_busy), .O_done(O_done),
    .O_quotient(O_quotient), .O_remainder(O_remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: truncating division in 64-bit arithmetic; b==0 gives all ones / dividend.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 0) return {32'hFFFF_FFFF, a};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {q[31:0], r[31:0]};
    end
    return {a / b, a % b};
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    I_a = a; I_b = b; I_signed = s; I_start = 1'b1;
    @(posedge clk);
    #1 I_start = 1'b0;
  endtask

  // Counts cycles after the start edge until O_done; optionally pulses a 9/2 start at cycle inj.
  task automatic wait_done(input int inj, output int lat, output int busy_bad);
    lat = 0; busy_bad = 0;
    while (lat < 60) begin
      @(posedge clk); #1;
      lat++;
      I_start = 1'b0;
      if (O_done) break;
      if (!O_busy) busy_bad++;
      if (lat == inj) begin
        I_a = 9; I_b = 2; I_signed = 1'b0; I_start = 1'b1;
      end
    end
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input int inj, input logic [31:0] eq, input logic [31:0] er);
    int lat, bb;
    start_op(a, b, s);
    wait_done(inj, lat, bb);
    chk({tag, "_lat"}, lat, LAT);
    chk({tag, "_busy"}, bb, 0);
    chk({tag, "_busy_at_done"}, O_busy, 0);
    chk({tag, "_q"}, O_quotient, eq);
    chk({tag, "_r"}, O_remainder, er);
  endtask

  task automatic quiet(input string tag, input int n);
    int ev = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (O_done || O_busy) ev++;
    end
    chk(tag, ev, 0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    logic [63:0] e;
    int          lat, bb;
    I_reset = 1'b1; I_start = 1'b0; I_signed = 1'b0; I_a = '0; I_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", O_busy, 0);
    chk("rst_done", O_done, 0);
    chk("rst_q", O_quotient, 0);
    chk("rst_r", O_remainder, 0);
    @(negedge clk) I_reset = 1'b0;

    run_div("u100_7", 100, 7, 1'b0, -1, 14, 2);
    @(posedge clk); #1;
    chk("done_pulse", O_done, 0);
    chk("hold_q", O_quotient, 14);
    run_div("sm100_7", 32'hFFFF_FF9C, 7, 1'b1, -1, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    run_div("s100_m7", 100, 32'hFFFF_FFF9, 1'b1, -1, 32'hFFFF_FFF2, 2);
    run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, 32'h8000_0000, 0);
    run_div("u_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, 0, 32'h8000_0000);
    run_div("u_max_1", 32'hFFFF_FFFF, 1, 1'b0, -1, 32'hFFFF_FFFF, 0);
    run_div("u_div0", 5, 0, 1'b0, -1, 32'hFFFF_FFFF, 5);
    run_div("s_div0", 32'hFFFF_FFFB, 0, 1'b1, -1, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

    // Start while busy is dropped
    run_div("busy_ign", 100, 7, 1'b0, 10, 14, 2);
    quiet("busy_ign_drop", 40);

    // Start in the done cycle is accepted
    run_div("b2b_first", 100, 7, 1'b0, -1, 14, 2);
    run_div("b2b_second", 9, 2, 1'b0, -1, 4, 1);

    // Reset mid-division
    start_op(100, 7, 1'b0);
    repeat (13) @(posedge clk);
    @(negedge clk) I_reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy", O_busy, 0);
    chk("mid_rst_done", O_done, 0);
    chk("mid_rst_q", O_quotient, 0);
    chk("mid_rst_r", O_remainder, 0);
    @(negedge clk) I_reset = 1'b0;
    quiet("mid_rst_no_done", 40);
    run_div("post_rst", 100, 7, 1'b0, -1, 14, 2);

    for (int i = 0; i < 60; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: b = 0;
        1: b = $urandom_range(1, 15);
        2: a = 32'h8000_0000;
        3: b = s ? 32'hFFFF_FFFF : 32'($urandom_range(1, 255));
        default: ;
      endcase
      e = ref_div(a, b, s);
      start_op(a, b, s);
      wait_done(-1, lat, bb);
      chk("rnd_lat", lat, LAT);
      chk("rnd_q", O_quotient, e[63:32]);
      chk("rnd_r", O_remainder, e[31:0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
